// File: rtl/hit_response.sv
// Hit/block event receiver: per-player health, hit-stun, invulnerability and KO,
// plus the round FSM that holds after a KO and reports the winner.
module hit_response #(
   parameter logic [7:0]  MAX_HEALTH     = 8'd100,
   parameter logic [7:0]  HIT_DAMAGE     = 8'd10,
   parameter logic [7:0]  CHIP_DAMAGE    = 8'd2,
   parameter int unsigned STUN_FRAMES    = 20,
   parameter int unsigned INVULN_FRAMES  = 30,
   parameter int unsigned KO_HOLD_FRAMES = 120
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       round_start,
   input  logic       hitP1,
   input  logic       hitP2,
   input  logic       blockP1,
   input  logic       blockP2,
   output logic [7:0] healthP1,
   output logic [7:0] healthP2,
   output logic       stunP1,
   output logic       stunP2,
   output logic       invulnP1,
   output logic       invulnP2,
   output logic       koP1,
   output logic       koP2,
   output logic       dmg_ackP1,
   output logic       dmg_ackP2,
   output logic       round_over,
   output logic [1:0] winner
);

   typedef enum logic [1:0] {P_IDLE, P_STUN, P_INVULN, P_KO} pstate_t;
   typedef enum logic [1:0] {R_FIGHT, R_KO_HOLD, R_DONE} rstate_t;

   localparam logic [15:0] LP_STUN   = 16'(STUN_FRAMES);
   localparam logic [15:0] LP_INVULN = 16'(INVULN_FRAMES);
   localparam logic [15:0] LP_HOLD   = 16'(KO_HOLD_FRAMES);

   pstate_t     r_pst    [2];
   logic [7:0]  r_health [2];
   logic [15:0] r_pcnt   [2];
   logic        r_ack    [2];
   logic        r_hit_q  [2];
   logic        r_blk_q  [2];
   rstate_t     r_rst;
   logic [15:0] r_rcnt;
   logic [1:0]  r_winner;

   logic       w_hit    [2];
   logic       w_blk    [2];
   logic       w_blk_ev [2];
   logic       w_accept [2];
   logic [7:0] w_dmg    [2];
   logic       w_ko_now [2];

   assign w_hit[0] = hitP1;
   assign w_hit[1] = hitP2;
   assign w_blk[0] = blockP1;
   assign w_blk[1] = blockP2;

   // Only an idle player in a live round can take damage; block outranks hit.
   always_comb begin
      for (int unsigned i = 0; i < 2; i++) begin
         w_blk_ev[i] = w_blk[i] & ~r_blk_q[i];
         w_accept[i] = (r_rst == R_FIGHT) && !round_start && (r_pst[i] == P_IDLE) &&
                       (w_blk_ev[i] || (w_hit[i] & ~r_hit_q[i]));
         w_dmg[i]    = w_blk_ev[i] ? CHIP_DAMAGE : HIT_DAMAGE;
         w_ko_now[i] = w_accept[i] && (w_dmg[i] >= r_health[i]);
      end
   end

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_pst[i]    <= P_IDLE;
            r_health[i] <= MAX_HEALTH;
            r_pcnt[i]   <= '0;
            r_ack[i]    <= 1'b0;
            r_hit_q[i]  <= 1'b0;
            r_blk_q[i]  <= 1'b0;
         end
         r_rst    <= R_FIGHT;
         r_rcnt   <= '0;
         r_winner <= '0;
      end else begin
         for (int unsigned i = 0; i < 2; i++) begin
            r_hit_q[i] <= w_hit[i];
            r_blk_q[i] <= w_blk[i];
         end
         if (round_start) begin
            for (int unsigned i = 0; i < 2; i++) begin
               r_pst[i]    <= P_IDLE;
               r_health[i] <= MAX_HEALTH;
               r_pcnt[i]   <= '0;
               r_ack[i]    <= 1'b0;
            end
            r_rst    <= R_FIGHT;
            r_rcnt   <= '0;
            r_winner <= '0;
         end else begin
            for (int unsigned i = 0; i < 2; i++) begin
               r_ack[i] <= w_accept[i];
               case (r_pst[i])
                  P_IDLE: begin
                     if (w_ko_now[i]) begin
                        r_health[i] <= '0;
                        r_pst[i]    <= P_KO;
                     end else if (w_accept[i]) begin
                        r_health[i] <= r_health[i] - w_dmg[i];
                        r_pst[i]    <= w_blk_ev[i] ? P_INVULN : P_STUN;
                        r_pcnt[i]   <= w_blk_ev[i] ? LP_INVULN : LP_STUN;
                     end
                  end
                  P_STUN: begin
                     if (r_pcnt[i] == 16'd1) begin
                        r_pst[i]  <= P_INVULN;
                        r_pcnt[i] <= LP_INVULN;
                     end else begin
                        r_pcnt[i] <= r_pcnt[i] - 16'd1;
                     end
                  end
                  P_INVULN: begin
                     if (r_pcnt[i] == 16'd1) begin
                        r_pst[i]  <= P_IDLE;
                        r_pcnt[i] <= '0;
                     end else begin
                        r_pcnt[i] <= r_pcnt[i] - 16'd1;
                     end
                  end
                  default: r_pcnt[i] <= '0;
               endcase
            end
            case (r_rst)
               R_FIGHT: begin
                  if (w_ko_now[0] || w_ko_now[1]) begin
                     r_rst    <= R_KO_HOLD;
                     r_rcnt   <= LP_HOLD;
                     r_winner <= {w_ko_now[0], w_ko_now[1]};
                  end
               end
               R_KO_HOLD: begin
                  if (r_rcnt == 16'd1) begin
                     r_rst  <= R_DONE;
                     r_rcnt <= '0;
                  end else begin
                     r_rcnt <= r_rcnt - 16'd1;
                  end
               end
               default: r_rst <= R_DONE;
            endcase
         end
      end
   end

   assign healthP1   = r_health[0];
   assign healthP2   = r_health[1];
   assign stunP1     = (r_pst[0] == P_STUN);
   assign stunP2     = (r_pst[1] == P_STUN);
   assign invulnP1   = (r_pst[0] == P_INVULN);
   assign invulnP2   = (r_pst[1] == P_INVULN);
   assign koP1       = (r_pst[0] == P_KO);
   assign koP2       = (r_pst[1] == P_KO);
   assign dmg_ackP1  = r_ack[0];
   assign dmg_ackP2  = r_ack[1];
   assign round_over = (r_rst == R_DONE);
   assign winner     = r_winner;

endmodule

// File: tb/tb_hit_response.sv
// Directed bench for hit_response: a frame-number model (damage, busy windows, KO frame)
// checked every frame, plus literal expectations at key points.
module tb_hit_response;

   localparam int MAXH = 100, HITD = 10, CHIPD = 2, STUNF = 20, INVF = 30, HOLDF = 120;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b0, round_start = 1'b0;
   logic       hitP1 = 1'b0, hitP2 = 1'b0, blockP1 = 1'b0, blockP2 = 1'b0;
   logic [7:0] healthP1, healthP2;
   logic       stunP1, stunP2, invulnP1, invulnP2, koP1, koP2, dmg_ackP1, dmg_ackP2;
   logic       round_over;
   logic [1:0] winner;

   int checks = 0, failures = 0;
   bit chk_en = 1'b0;

   hit_response #(
      .MAX_HEALTH(8'(MAXH)), .HIT_DAMAGE(8'(HITD)), .CHIP_DAMAGE(8'(CHIPD)),
      .STUN_FRAMES(STUNF), .INVULN_FRAMES(INVF), .KO_HOLD_FRAMES(HOLDF)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .round_start(round_start),
      .hitP1(hitP1), .hitP2(hitP2), .blockP1(blockP1), .blockP2(blockP2),
      .healthP1(healthP1), .healthP2(healthP2), .stunP1(stunP1), .stunP2(stunP2),
      .invulnP1(invulnP1), .invulnP2(invulnP2), .koP1(koP1), .koP2(koP2),
      .dmg_ackP1(dmg_ackP1), .dmg_ackP2(dmg_ackP2), .round_over(round_over), .winner(winner)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: n = frame index; a player is busy until frame m_idle, stunned before m_stunend.
   int m_n, m_koedge, m_winner;
   int m_health[2], m_idle[2], m_stunend[2];
   bit m_ko[2], m_ack[2], m_phit[2], m_pblk[2];

   always @(posedge frame_clk or negedge Reset) begin
      bit h[2], b[2], newko[2], fighting, blocked;
      int dmg;
      h[0] = hitP1; h[1] = hitP2; b[0] = blockP1; b[1] = blockP2;
      if (!Reset) begin
         m_n = 0; m_koedge = -1; m_winner = 0;
         for (int i = 0; i < 2; i++) begin
            m_health[i] = MAXH; m_idle[i] = 0; m_stunend[i] = 0;
            m_ko[i] = 0; m_ack[i] = 0; m_phit[i] = 0; m_pblk[i] = 0;
         end
      end else begin
         m_n++;
         if (round_start) begin
            m_koedge = -1; m_winner = 0;
            for (int i = 0; i < 2; i++) begin
               m_health[i] = MAXH; m_idle[i] = m_n; m_stunend[i] = m_n;
               m_ko[i] = 0; m_ack[i] = 0;
            end
         end else begin
            fighting = (m_koedge < 0);
            for (int i = 0; i < 2; i++) begin
               newko[i] = 0; m_ack[i] = 0;
               blocked = b[i] && !m_pblk[i];
               if (fighting && !m_ko[i] && m_n > m_idle[i] && (blocked || (h[i] && !m_phit[i]))) begin
                  dmg = blocked ? CHIPD : HITD;
                  m_ack[i] = 1;
                  if (dmg >= m_health[i]) begin
                     m_health[i] = 0; m_ko[i] = 1; newko[i] = 1;
                  end else begin
                     m_health[i] -= dmg;
                     m_stunend[i] = blocked ? m_n : m_n + STUNF;
                     m_idle[i]    = m_stunend[i] + INVF;
                  end
               end
            end
            if (newko[0] || newko[1]) begin
               m_koedge = m_n;
               m_winner = (newko[0] ? 2 : 0) + (newko[1] ? 1 : 0);
            end
         end
         for (int i = 0; i < 2; i++) begin
            m_phit[i] = h[i]; m_pblk[i] = b[i];
         end
      end
   end

   always @(negedge frame_clk) begin
      if (chk_en) begin
         chk("healthP1", healthP1, m_health[0]);
         chk("healthP2", healthP2, m_health[1]);
         chk("stunP1", stunP1, int'(!m_ko[0] && m_n < m_stunend[0]));
         chk("stunP2", stunP2, int'(!m_ko[1] && m_n < m_stunend[1]));
         chk("invulnP1", invulnP1, int'(!m_ko[0] && m_n >= m_stunend[0] && m_n < m_idle[0]));
         chk("invulnP2", invulnP2, int'(!m_ko[1] && m_n >= m_stunend[1] && m_n < m_idle[1]));
         chk("koP1", koP1, m_ko[0]);
         chk("koP2", koP2, m_ko[1]);
         chk("dmg_ackP1", dmg_ackP1, m_ack[0]);
         chk("dmg_ackP2", dmg_ackP2, m_ack[1]);
         chk("round_over", round_over, int'(m_koedge >= 0 && m_n >= m_koedge + HOLDF));
         chk("winner", winner, m_winner);
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge frame_clk);
   endtask

   task automatic pulse(input bit h1, input bit h2, input bit b1, input bit b2, input int idle_wait);
      hitP1 = h1; hitP2 = h2; blockP1 = b1; blockP2 = b2;
      step(1);
      hitP1 = 0; hitP2 = 0; blockP1 = 0; blockP2 = 0;
      step(idle_wait);
   endtask

   initial begin
      step(2);
      chk("rst_healthP1", healthP1, 100);
      chk("rst_healthP2", healthP2, 100);
      chk("rst_winner", winner, 0);
      chk("rst_round_over", round_over, 0);
      chk_en = 1'b1;
      Reset = 1'b1;
      step(2);

      // Held hit gives one event, 20 frames stun then 30 frames invuln
      hitP2 = 1; step(1);
      chk("t1_health", healthP2, 90);
      chk("t1_ack", dmg_ackP2, 1);
      step(2); hitP2 = 0;
      chk("t1_ack_once", dmg_ackP2, 0);
      step(17);
      chk("t1_stun_last", stunP2, 1);
      step(1);
      chk("t1_stun_end", stunP2, 0);
      chk("t1_invuln", invulnP2, 1);
      step(30);
      chk("t1_idle", invulnP2, 0);

      // Block and hit together: chip only
      blockP1 = 1; hitP1 = 1; step(1);
      chk("t2_health", healthP1, 98);
      chk("t2_stun", stunP1, 0);
      chk("t2_invuln", invulnP1, 1);
      blockP1 = 0; hitP1 = 0; step(31);

      // Pulses every 5 frames: only the first and the one after the busy window land
      for (int k = 0; k < 12; k++) pulse(0, 1, 0, 0, 4);
      chk("t3_health", healthP2, 70);
      step(55);

      // Drive P2 to 8 then a hit KOs it
      for (int k = 0; k < 6; k++) pulse(0, 1, 0, 0, 55);
      pulse(0, 0, 0, 1, 31);
      chk("t4_health8", healthP2, 8);
      hitP2 = 1; step(1); hitP2 = 0;
      chk("t4_health0", healthP2, 0);
      chk("t4_ko", koP2, 1);
      chk("t4_stun", stunP2, 0);
      hitP1 = 1; step(1); hitP1 = 0;
      chk("t4_survivor", healthP1, 98);
      step(117);
      chk("t4_hold", round_over, 0);
      step(1);
      chk("t4_hold_last", round_over, 0);
      step(1);
      chk("t4_over", round_over, 1);
      chk("t4_winner", winner, 1);

      round_start = 1; step(1); round_start = 0;
      chk("t5_rs_h1", healthP1, 100);
      chk("t5_rs_over", round_over, 0);
      for (int k = 0; k < 9; k++) pulse(1, 1, 0, 0, 55);
      chk("t5_h1_10", healthP1, 10);
      chk("t5_h2_10", healthP2, 10);
      hitP1 = 1; hitP2 = 1; step(1); hitP1 = 0; hitP2 = 0;
      chk("t5_ko1", koP1, 1);
      chk("t5_ko2", koP2, 1);
      chk("t5_draw", winner, 3);
      step(120);
      chk("t5_over", round_over, 1);
      hitP1 = 1; round_start = 1; step(1); round_start = 0;
      chk("t5_restart_h1", healthP1, 100);
      chk("t5_restart_h2", healthP2, 100);
      chk("t5_restart_over", round_over, 0);
      chk("t5_restart_winner", winner, 0);
      step(3);
      chk("t5_held_nodmg", healthP1, 100);
      hitP1 = 0; step(1);
      hitP1 = 1; step(1); hitP1 = 0;
      chk("t5_rearm", healthP1, 90);

      // Asynchronous reset mid-stun
      step(55);
      pulse(1, 0, 0, 0, 55);
      hitP1 = 1; step(1); hitP1 = 0;
      chk("t6_h70", healthP1, 70);
      step(5);
      #2 Reset = 0;
      #1;
      chk("t6_async_health", healthP1, 100);
      chk("t6_async_stun", stunP1, 0);
      chk("t6_async_ack", dmg_ackP1, 0);
      @(negedge frame_clk);
      Reset = 1;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
